// File: rtl/mult_pkg.sv
// Shared definitions for the MULTU sequencing controller: state encoding and iteration counter sizing.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MULT_ITERS = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } mult_state_e;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder with carry in/out and signed-overflow flag.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  logic [32:0] c;

  always_comb begin
    c[0] = carry_in;
    for (int i = 0; i < 32; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[32];
    overflow  = c[32] ^ c[31];
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add sequencer for unsigned 32x32 -> 64 MULTU, reusing one adder_32bit for 32 iterations.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = MULT_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  adder_32bit u_adder (
    .a         (acc_hi_q),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co),
    .overflow  ()
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = multiplicand;
          acc_hi_d = '0;
          acc_lo_d = multiplier;
          count_d  = '0;
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        // Carry-out lands in the MSB, so the 33-bit partial sum never overflows.
        acc_hi_d = {add_co, add_sum[WIDTH-1:1]};
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(ITERS - 1)) begin
          state_d   = S_DONE;
          prod_hi_d = acc_hi_d;
          prod_lo_d = acc_lo_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      count_q   <= count_d;
    end
  end

  assign busy       = (state_q == S_CALC);
  assign done       = (state_q == S_DONE);
  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: table of operand/product vectors plus hand-written corner sequences.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int tests  = 0;
  int failed = 0;

  mult_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Start one operation and follow it to done, checking latency, busy length and product.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " product"}, {product_hi, product_lo}, exp);
    @(negedge clk);
    check({tag, " done_after"}, 64'(done), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " product_held"}, {product_hi, product_lo}, exp);
  endtask

  vec_t vecs[5];

  initial begin
    int cyc;
    int busy_cnt;
    int stray;

    vecs[0] = '{32'd3,        32'd5,        64'h0000_0000_0000_000F, "3x5"};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max"};
    vecs[2] = '{32'h1234_5678, 32'd0,        64'd0,                   "a_x0"};
    vecs[3] = '{32'd0,        32'h9ABC_DEF0, 64'd0,                   "0_xb"};
    vecs[4] = '{32'd2,        32'h8000_0000, 64'h0000_0001_0000_0000, "2x8000"};

    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // start pulsed during CALC cycle 10 with different operands must be ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (cyc == 10) begin start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("ignore latency", 64'(cyc), 64'd33);
    check("ignore product", {product_hi, product_lo}, 64'h2A);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    check("ignore no_second_op", 64'(stray), 64'd0);
    check("ignore product_held", {product_hi, product_lo}, 64'h2A);

    // reset in CALC cycle 15 aborts at once
    @(negedge clk);
    start = 1'b1; multiplicand = 32'h0001_0000; multiplier = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    check("abort no_done", 64'(stray), 64'd0);
    run_op(32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000, "post_abort");

    // back-to-back: start held through DONE, new operands presented in DONE
    @(negedge clk);
    start = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first latency", 64'(cyc), 64'd33);
    check("b2b first product", {product_hi, product_lo}, 64'hF);
    multiplicand = 32'd9; multiplier = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("b2b no_idle_gap busy", 64'(busy), 64'd1);
    check("b2b no_idle_gap done", 64'(done), 64'd0);
    check("b2b product_stable_in_calc", {product_hi, product_lo}, 64'hF);
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("b2b second latency", 64'(cyc), 64'd33);
    check("b2b second busy_cycles", 64'(busy_cnt), 64'd32);
    check("b2b second product", {product_hi, product_lo}, 64'd81);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
